// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared types and defaults for the multi-port register file
//               and its register-dump engine.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    // Default architectural shape (RV32 integer file)
    localparam int c_DEFAULT_XLEN  = 32;
    localparam int c_DEFAULT_NREGS = 32;

    // Dump engine states
    typedef enum logic [0:0] {
        DUMP_IDLE   = 1'b0,
        DUMP_STREAM = 1'b1
    } dump_state_t;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_if
// Description : Read/write/dump bus of the multi-port register file.
//               master = core/debug side, slave = register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int XLEN     = c_DEFAULT_XLEN,
    parameter int NREGS    = c_DEFAULT_NREGS,
    parameter int NR_READ  = 2,
    parameter int NR_WRITE = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NR_READ*AW-1:0]    rs_addr;
    logic [NR_READ*XLEN-1:0]  rs_data;
    logic [NR_WRITE-1:0]      we;
    logic [NR_WRITE*AW-1:0]   rd_addr;
    logic [NR_WRITE*XLEN-1:0] rd_data;
    logic                     dump_start;
    logic                     dump_busy;
    logic                     dump_valid;
    logic                     dump_ready;
    logic [AW-1:0]            dump_idx;
    logic [XLEN-1:0]          dump_data;
    logic                     dump_last;

    modport master (
        output rs_addr, we, rd_addr, rd_data, dump_start, dump_ready,
        input  rs_data, dump_busy, dump_valid, dump_idx, dump_data, dump_last
    );

    modport slave (
        input  rs_addr, we, rd_addr, rd_data, dump_start, dump_ready,
        output rs_data, dump_busy, dump_valid, dump_idx, dump_data, dump_last
    );

endinterface : reg_file_if
`default_nettype wire

// File: rtl/reg_file_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_dump_ctrl
// Description : Register-dump engine. Walks indices 0..NREGS-1 and presents
//               one snapshot beat per register on a valid/ready stream. The
//               value of each beat is captured from a dedicated array read
//               port at the edge that advances to it, so later writes to the
//               presented register never disturb the beat.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_dump_ctrl
    import reg_file_pkg::*;
#(
    parameter int XLEN  = c_DEFAULT_XLEN,
    parameter int NREGS = c_DEFAULT_NREGS,
    localparam int AW   = $clog2(NREGS)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_dump_start,
    input  wire logic            i_dump_ready,
    input  wire logic [XLEN-1:0] i_rd_data,
    output logic      [AW-1:0]   o_rd_addr,
    output logic                 o_dump_busy,
    output logic                 o_dump_valid,
    output logic      [AW-1:0]   o_dump_idx,
    output logic      [XLEN-1:0] o_dump_data,
    output logic                 o_dump_last
);

    localparam logic [AW-1:0] c_LAST_IDX = AW'(NREGS - 1);

    dump_state_t     r_state;
    logic            r_busy;
    logic            r_valid;
    logic            r_last;
    logic [AW-1:0]   r_idx;
    logic [XLEN-1:0] r_data;

    logic [AW-1:0]   w_next_idx;
    logic            w_fire;

    assign w_next_idx = r_idx + AW'(1);
    assign w_fire     = r_valid & i_dump_ready;

    // Look-ahead address: register 0 while idle, the next beat while streaming
    assign o_rd_addr = (r_state == DUMP_STREAM) ? w_next_idx : '0;

    // Dump FSM with registered stream outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DUMP_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                DUMP_IDLE: begin
                    if (i_dump_start) begin
                        r_state <= DUMP_STREAM;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
                        r_idx   <= '0;
                        r_data  <= i_rd_data;
                        r_last  <= (c_LAST_IDX == '0);
                    end
                end
                DUMP_STREAM: begin
                    // dump_start is deliberately ignored in this state
                    if (w_fire) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= DUMP_IDLE;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_idx   <= '0;
                            r_data  <= '0;
                        end else begin
                            r_idx  <= w_next_idx;
                            r_data <= i_rd_data;
                            r_last <= (w_next_idx == c_LAST_IDX);
                        end
                    end
                end
                default: r_state <= DUMP_IDLE;
            endcase
        end
    end

    assign o_dump_busy  = r_busy;
    assign o_dump_valid = r_valid;
    assign o_dump_idx   = r_idx;
    assign o_dump_data  = r_data;
    assign o_dump_last  = r_last;

endmodule : reg_file_dump_ctrl
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp
// Description : Parametrised multi-port integer register file with
//               asynchronous clear, highest-port-wins write priority and a
//               hardware register-dump stream.
//               Optional macro REG_FILE_BYPASS_EN enables same-cycle
//               write-to-read forwarding on the rs ports (never on dump).
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN     = c_DEFAULT_XLEN,
    parameter int NREGS    = c_DEFAULT_NREGS,
    parameter int NR_READ  = 2,
    parameter int NR_WRITE = 1,
    parameter int ZERO_REG = 1
) (
    input wire logic  clk,
    input wire logic  rst,
    reg_file_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [XLEN-1:0] w_rs_val [NR_READ];
    logic [AW-1:0]   w_dump_addr;
    logic [XLEN-1:0] w_dump_rdata;

    // Array update; ascending port loop lets the highest port win on conflicts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NR_WRITE; j++) begin
                if (bus.we[j] && !((ZERO_REG != 0) && (bus.rd_addr[j*AW +: AW] == '0))) begin
                    r_regs[bus.rd_addr[j*AW +: AW]] <= bus.rd_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < NR_READ; i++) begin : g_rd_port
            logic [AW-1:0] w_addr;
            assign w_addr = bus.rs_addr[i*AW +: AW];

            // Combinational read, optionally forwarded from this cycle's writes
            always_comb begin
                w_rs_val[i] = r_regs[w_addr];
`ifdef REG_FILE_BYPASS_EN
                for (int j = 0; j < NR_WRITE; j++) begin
                    if (bus.we[j] && (bus.rd_addr[j*AW +: AW] == w_addr)) begin
                        w_rs_val[i] = bus.rd_data[j*XLEN +: XLEN];
                    end
                end
`endif
                if ((ZERO_REG != 0) && (w_addr == '0)) begin
                    w_rs_val[i] = '0;
                end
            end
        end : g_rd_port
    endgenerate

    // Pack per-port read values onto the bus
    always_comb begin
        bus.rs_data = '0;
        for (int i = 0; i < NR_READ; i++) begin
            bus.rs_data[i*XLEN +: XLEN] = w_rs_val[i];
        end
    end

    // Dedicated, never-forwarded read port for the dump engine
    assign w_dump_rdata = ((ZERO_REG != 0) && (w_dump_addr == '0)) ? '0 : r_regs[w_dump_addr];

    reg_file_dump_ctrl #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_dump_ctrl (
        .clk          (clk),
        .rst          (rst),
        .i_dump_start (bus.dump_start),
        .i_dump_ready (bus.dump_ready),
        .i_rd_data    (w_dump_rdata),
        .o_rd_addr    (w_dump_addr),
        .o_dump_busy  (bus.dump_busy),
        .o_dump_valid (bus.dump_valid),
        .o_dump_idx   (bus.dump_idx),
        .o_dump_data  (bus.dump_data),
        .o_dump_last  (bus.dump_last)
    );

endmodule : reg_file_mp
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_mp
// Description : Self-checking bench for reg_file_mp (2 read, 2 write ports).
//               Works with and without REG_FILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NR_READ = 2;
    localparam int NR_WRITE = 2;
`ifdef REG_FILE_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] m_regs [NREGS];

    reg_file_if #(.XLEN(XLEN), .NREGS(NREGS), .NR_READ(NR_READ), .NR_WRITE(NR_WRITE)) bus ();

    reg_file_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NR_READ(NR_READ), .NR_WRITE(NR_WRITE), .ZERO_REG(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0_nb;
        logic [31:0] e1_nb;
        logic [31:0] e0_b;
        logic [31:0] e1_b;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1,
                         input logic [4:0] r0, input logic [4:0] r1);
        bus.we      = we;
        bus.rd_addr = {a1, a0};
        bus.rd_data = {d1, d0};
        bus.rs_addr = {r1, r0};
    endtask

    // Reference read: stored value, or the highest enabled matching write port when forwarding
    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] v;
        if (a == 5'd0) return 32'h0;
        v = m_regs[a];
        if (c_BYP) begin
            for (int j = 0; j < NR_WRITE; j++) begin
                if (bus.we[j] && bus.rd_addr[j*5 +: 5] == a) v = bus.rd_data[j*32 +: 32];
            end
        end
        return v;
    endfunction

    task automatic model_write();
        for (int j = 0; j < NR_WRITE; j++) begin
            if (bus.we[j] && bus.rd_addr[j*5 +: 5] != 5'd0)
                m_regs[bus.rd_addr[j*5 +: 5]] = bus.rd_data[j*32 +: 32];
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NREGS; k++) m_regs[k] = 32'h0;
    endtask

    // One cycle: inputs already driven; sample at negedge, commit model, move past edge
    task automatic finish_cycle();
        @(negedge clk);
        model_write();
        @(posedge clk);
        #1;
    endtask

    // Fill every register with val_base + k*step via both write ports
    task automatic preload(input logic [31:0] base, input logic [31:0] step);
        for (int k = 0; k < NREGS; k += 2) begin
            drive(2'b11, 5'(k), base + 32'(k) * step, 5'(k + 1), base + 32'(k + 1) * step, 5'd0, 5'd0);
            finish_cycle();
        end
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
    endtask

    // Run a dump. mode 0: ready 1,0,0 pattern, stall writes to the presented
    // register, a mid-stream start, and a start on the final handshake.
    // mode 1: ready always high. abort_at >= 0 asserts rst while that index is presented.
    task automatic dump_run(input int mode, input int abort_at);
        logic [31:0] snap [NREGS];
        int exp_idx;
        int beats;
        int cyc;
        bit rdy;
        bit aborted;
        for (int k = 0; k < NREGS; k++) snap[k] = m_regs[k];
        exp_idx = 0;
        beats = 0;
        aborted = 1'b0;
        bus.dump_start = 1'b1;
        bus.dump_ready = 1'b0;
        finish_cycle();
        bus.dump_start = 1'b0;
        for (cyc = 0; cyc < 400 && beats < NREGS && !aborted; cyc++) begin
            if (exp_idx == abort_at) begin
                #2 rst = 1'b1;
                #1;
                model_clear();
                check("abort_valid", 32'(bus.dump_valid), 32'h0);
                check("abort_busy", 32'(bus.dump_busy), 32'h0);
                check("abort_idx", 32'(bus.dump_idx), 32'h0);
                check("abort_data", bus.dump_data, 32'h0);
                bus.rs_addr = {5'd31, 5'd5};
                #1;
                check("abort_rs0", bus.rs_data[31:0], 32'h0);
                check("abort_rs1", bus.rs_data[63:32], 32'h0);
                @(posedge clk);
                #1 rst = 1'b0;
                aborted = 1'b1;
            end else begin
                if (mode == 0) begin
                    rdy = (exp_idx == NREGS - 1) ? 1'b1 : (cyc % 3 == 0);
                    bus.dump_start = (exp_idx == NREGS - 1) || (cyc == 20);
                    if (!rdy)
                        drive(2'b01, 5'(exp_idx), 32'hDEAD0000 | 32'(cyc), 5'd0, 32'h0, 5'd0, 5'd0);
                    else
                        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
                end else begin
                    rdy = 1'b1;
                end
                bus.dump_ready = rdy;
                @(negedge clk);
                check("dump_valid", 32'(bus.dump_valid), 32'h1);
                check("dump_busy", 32'(bus.dump_busy), 32'h1);
                check("dump_idx", 32'(bus.dump_idx), 32'(exp_idx));
                check("dump_data", bus.dump_data, snap[exp_idx]);
                check("dump_last", 32'(bus.dump_last), 32'(exp_idx == NREGS - 1));
                if (bus.dump_valid && rdy) begin
                    beats++;
                    exp_idx++;
                end
                model_write();
                @(posedge clk);
                #1;
                bus.dump_start = 1'b0;
                drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
            end
        end
        bus.dump_ready = 1'b0;
        if (!aborted) begin
            check("dump_beats", 32'(beats), 32'(NREGS));
            check("dump_end_valid", 32'(bus.dump_valid), 32'h0);
            check("dump_end_busy", 32'(bus.dump_busy), 32'h0);
            check("dump_end_last", 32'(bus.dump_last), 32'h0);
            finish_cycle();
            check("dump_no_restart", 32'(bus.dump_valid), 32'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b01, 5'd5, 32'h12345678, 5'd0, 32'h0,    5'd5, 5'd0, 32'h0,        32'h0,        32'h12345678, 32'h0};
        vecs[1] = '{2'b01, 5'd0, 32'h0000DEAD, 5'd0, 32'h0,    5'd0, 5'd5, 32'h0,        32'h12345678, 32'h0,        32'h12345678};
        vecs[2] = '{2'b11, 5'd7, 32'h00001111, 5'd7, 32'h2222, 5'd5, 5'd7, 32'h12345678, 32'h0,        32'h12345678, 32'h2222};
        vecs[3] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd7, 5'd0, 32'h2222,     32'h0,        32'h2222,     32'h0};
        vecs[4] = '{2'b01, 5'd3, 32'h0000ABCD, 5'd0, 32'h0,    5'd7, 5'd3, 32'h2222,     32'h0,        32'h2222,     32'hABCD};
        vecs[5] = '{2'b10, 5'd3, 32'h0,        5'd3, 32'hBEEF, 5'd3, 5'd5, 32'hABCD,     32'h12345678, 32'hBEEF,     32'h12345678};
        vecs[6] = '{2'b11, 5'd9, 32'h0000AAAA, 5'd0, 32'h5555, 5'd9, 5'd0, 32'h0,        32'h0,        32'hAAAA,     32'h0};
        vecs[7] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd3, 5'd9, 32'hBEEF,     32'hAAAA,     32'hBEEF,     32'hAAAA};
        vecs[8] = '{2'b11, 5'd4, 32'h00000001, 5'd4, 32'h2,    5'd4, 5'd4, 32'h0,        32'h0,        32'h2,        32'h2};
        vecs[9] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    5'd4, 5'd0, 32'h2,        32'h0,        32'h2,        32'h0};

        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b0;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd31);
        model_clear();

        // Reset state
        #22;
        check("rst_rs0", bus.rs_data[31:0], 32'h0);
        check("rst_rs1", bus.rs_data[63:32], 32'h0);
        check("rst_valid", 32'(bus.dump_valid), 32'h0);
        check("rst_busy", 32'(bus.dump_busy), 32'h0);
        check("rst_idx", 32'(bus.dump_idx), 32'h0);
        check("rst_data", bus.dump_data, 32'h0);
        check("rst_last", 32'(bus.dump_last), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Preload all ones, then clear asynchronously mid-cycle
        preload(32'hFFFFFFFF, 32'h0);
        bus.rs_addr = {5'd31, 5'd5};
        #1;
        check("pre_rs0", bus.rs_data[31:0], 32'hFFFFFFFF);
        check("pre_rs1", bus.rs_data[63:32], 32'hFFFFFFFF);
        #1 rst = 1'b1;
        #1;
        model_clear();
        for (int k = 0; k < NREGS; k += 4) begin
            bus.rs_addr = {5'(31 - k), 5'(k)};
            #0.5;
            check("clr_rs0", bus.rs_data[31:0], 32'h0);
            check("clr_rs1", bus.rs_data[63:32], 32'h0);
        end
        check("clr_valid", 32'(bus.dump_valid), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed vector table
        for (int v = 0; v < 10; v++) begin
            drive(vecs[v].we, vecs[v].a0, vecs[v].d0, vecs[v].a1, vecs[v].d1, vecs[v].r0, vecs[v].r1);
            @(negedge clk);
            check("vec_rs0", bus.rs_data[31:0], c_BYP ? vecs[v].e0_b : vecs[v].e0_nb);
            check("vec_rs1", bus.rs_data[63:32], c_BYP ? vecs[v].e1_b : vecs[v].e1_nb);
            model_write();
            @(posedge clk);
            #1;
        end

        // Randomised traffic against the reference model
        for (int n = 0; n < 300; n++) begin
            drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            @(negedge clk);
            check("rnd_rs0", bus.rs_data[31:0], model_read(bus.rs_addr[4:0]));
            check("rnd_rs1", bus.rs_data[63:32], model_read(bus.rs_addr[9:5]));
            model_write();
            @(posedge clk);
            #1;
        end

        // Full dump with stalls: xk = k*16
        preload(32'h0, 32'd16);
        dump_run(0, -1);

        // Dump aborted by reset at beat 10, then a clean dump of cleared registers
        preload(32'h0, 32'd16);
        dump_run(1, 10);
        dump_run(1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file_mp
`default_nettype wire

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port integer register file, successor to the 2R/1W RV32 register file. Adds the following:
- configurable width, depth and read/write port counts
- asynchronous clear
- deterministic write-port priority
- a hardware register-dump engine that streams every register over a valid/ready interface, replacing simulation-only printing

Sits in the decode/writeback stage of the RISC-V core. The dump port feeds the debug/UART path.

Parameters:
XLEN, 32, register data width in bits
NREGS, 32, number of architectural registers (power of two, >=2)
NR_READ, 2, number of combinational read ports (>=1)
NR_WRITE, 1, number of write ports (>=1)
ZERO_REG, 1, 1 = register 0 hardwired to zero and writes to it dropped; 0 = register 0 is ordinary
AW (localparam), $clog2(NREGS), address width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
rs_addr  in  NR_READ*AW  packed read addresses, port i at [i*AW +: AW]
rs_data  out  NR_READ*XLEN  packed read data, port i at [i*XLEN +: XLEN]
we  in  NR_WRITE  per-port write enable
rd_addr  in  NR_WRITE*AW  packed write addresses
rd_data  in  NR_WRITE*XLEN  packed write data
dump_start  in  1  pulse: begin dump of all registers
dump_busy  out  1  dump engine active
dump_valid  out  1  dump beat available
dump_ready  in  1  consumer accepts beat
dump_idx  out  AW  register index of current beat
dump_data  out  XLEN  register value of current beat
dump_last  out  1  current beat is index NREGS-1

Behaviour:
- Reset (async assert, applied immediately): all registers = 0; dump FSM to IDLE; dump_busy=0, dump_valid=0, dump_idx=0, dump_data=0, dump_last=0. Reset mid-dump aborts the dump; no further beats.
- Read: combinational, zero latency; rs_data[i] = registers[rs_addr[i]]. With ZERO_REG=1, address 0 always reads 0.
- Write: on the rising edge, for each port with we[j]=1, registers[rd_addr[j]] <= rd_data[j]. Dropped if ZERO_REG=1 and rd_addr[j]=0.
- Same-address simultaneous writes: the highest-numbered port wins.
- A write in cycle N is visible on reads in cycle N+1 (without the optional bypass).
- Dump FSM, IDLE -> STREAM:
  - IDLE: dump_start=1 -> STREAM, dump_idx=0, dump_data=registers[0] (value before that edge's writes), dump_valid=1, dump_busy=1.
  - STREAM: dump_valid=1. dump_idx/dump_data hold stable while dump_ready=0.
  - Writes to the register being presented during a stall are not reflected in dump_data (snapshot per beat).
  - Handshake (valid&ready) with idx<NREGS-1: idx+1, capture registers[idx+1] (pre-write value at that edge).
  - Handshake with idx=NREGS-1 -> IDLE, dump_valid=0, dump_busy=0.
  - dump_last = dump_valid && dump_idx==NREGS-1.
  - dump_start while in STREAM is ignored. dump_start on the same cycle as the final handshake is ignored (FSM is not yet IDLE).
- Dump never stalls or blocks reads/writes.

Optional Feature:
Macro REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding. If we[j] is active and rd_addr[j]==rs_addr[i] (and not a dropped zero-register write), rs_data[i] = rd_data[j] in the same cycle. On multiple matches, the highest j wins.
- Undefined: rs_data returns the stored value; the write is seen next cycle.
- The dump path never bypasses in either configuration.

Decomposition:
- Shared package reg_file_pkg:
  - dump FSM state enum (DUMP_IDLE, DUMP_STREAM)
  - default XLEN/NREGS constants
  - a clog2 helper function, if the toolchain needs one
- One natural sub-module: reg_file_dump_ctrl, containing the FSM, index counter, beat capture register and handshake. It receives a read-address output and a read-data input from the array.

Test Plan:
- Reset with all registers preloaded to 0xFFFFFFFF, assert rst mid-cycle -> all rs_data=0 immediately; dump_valid=0.
- Write port 0: x5=0x12345678 at edge N; read rs_addr[0]=5 -> 0x12345678 from cycle N+1. Write x0=0xDEAD -> reads 0 (ZERO_REG=1).
- NR_WRITE=2: both ports write x7 (0x1111 port0, 0x2222 port1) -> x7=0x2222.
- REG_FILE_BYPASS_EN defined: write x3=0xABCD with rs_addr[1]=3 in the same cycle -> rs_data[1]=0xABCD that cycle. Undefined -> old value that cycle, 0xABCD next cycle.
- Dump with xk=k*16, dump_ready toggling 1,0,0,1… -> exactly 32 beats, idx 0..31 in order, data k*16, dump_last only on idx 31, data stable during stalls; a dump_start mid-stream causes no restart.
- rst asserted at beat 10 of a dump -> dump_valid/dump_busy drop at once. A new dump_start then restarts from idx 0 with cleared (zero) data.
